// File: rtl/nnoc_pkg.sv
// Shared constants and types for the operand feeder and the result-side buffer.
package nnoc_pkg;

  localparam int N             = 4;
  localparam int STEPS         = 7;
  localparam int OPERAND_WIDTH = 32;

  typedef logic [OPERAND_WIDTH-1:0] operand_t;
  typedef logic [2:0]               step_t;

endpackage

// File: rtl/operand_feeder_lane.sv
// One skewed lane: picks row LANE, column (t-LANE), of the matrix while t is inside
// the lane's four-step window; drives zero with valid low outside it.
module feeder_lane
  import nnoc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANE  = 0
) (
  input  logic [N*N*WIDTH-1:0] mat_i,
  input  step_t                t_i,
  input  logic                 active_i,
  output logic [WIDTH-1:0]     data_o,
  output logic                 valid_o
);

  localparam step_t LANE_T = step_t'(LANE);

  step_t      rel_s;
  logic [3:0] elem_s;
  logic       in_window_s;

  // Window test and element selection for this lane.
  always_comb begin
    rel_s       = t_i - LANE_T;
    in_window_s = active_i && (t_i >= LANE_T) && (rel_s < step_t'(N));
    elem_s      = 4'(LANE * N) + {2'b00, rel_s[1:0]};
    if (in_window_s) begin
      data_o  = mat_i[int'(elem_s) * WIDTH +: WIDTH];
      valid_o = 1'b1;
    end else begin
      data_o  = '0;
      valid_o = 1'b0;
    end
  end

endmodule

// File: rtl/operand_feeder.sv
// Streams a captured 4x4 matrix into a systolic array as four skewed lanes over 7 steps.
// Define OPERAND_FEEDER_DOUBLE_BUFFER_EN to add a one-entry shadow matrix for gapless streams.
module operand_feeder #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N*N*WIDTH-1:0] mat_in,
  input  logic                 stall,
  output logic                 ready,
  output logic [N*WIDTH-1:0]   operand_port,
  output logic [N-1:0]         operand_valid,
  output logic                 busy,
  output logic                 done
);

  import nnoc_pkg::*;

  localparam step_t LAST_STEP = step_t'(STEPS - 1);

  step_t                t_q, t_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [N*N*WIDTH-1:0] mat_q, mat_d;
  logic [N*WIDTH-1:0]   port_q, port_d;
  logic [N-1:0]         valid_q, valid_d;
  logic                 accept_s;
  logic                 last_adv_s;

`ifdef OPERAND_FEEDER_DOUBLE_BUFFER_EN
  logic [N*N*WIDTH-1:0] shadow_q, shadow_d;
  logic                 shadow_full_q, shadow_full_d;

  assign ready = reset & ~(busy_q & shadow_full_q);
`else
  assign ready = reset & ~busy_q;
`endif

  assign accept_s   = start & ready;
  assign last_adv_s = busy_q & ~stall & (t_q == LAST_STEP);

  // Step sequencing, matrix capture and completion pulse.
  always_comb begin
    t_d    = t_q;
    busy_d = busy_q;
    done_d = 1'b0;
    mat_d  = mat_q;
`ifdef OPERAND_FEEDER_DOUBLE_BUFFER_EN
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
`endif
    if (!busy_q) begin
      if (accept_s) begin
        mat_d  = mat_in;
        busy_d = 1'b1;
        t_d    = 3'd0;
      end else begin
        t_d = 3'd0;
      end
    end else if (stall) begin
      t_d = t_q;
    end else if (last_adv_s) begin
      done_d = 1'b1;
      t_d    = 3'd0;
`ifdef OPERAND_FEEDER_DOUBLE_BUFFER_EN
      // A queued matrix (shadow, else one arriving right now) starts without a gap.
      if (shadow_full_q) begin
        mat_d         = shadow_q;
        shadow_full_d = 1'b0;
      end else if (accept_s) begin
        mat_d = mat_in;
      end else begin
        busy_d = 1'b0;
      end
`else
      busy_d = 1'b0;
`endif
    end else begin
      t_d = t_q + 3'd1;
    end
`ifdef OPERAND_FEEDER_DOUBLE_BUFFER_EN
    if (accept_s && busy_q && !last_adv_s) begin
      shadow_d      = mat_in;
      shadow_full_d = 1'b1;
    end else begin
      shadow_d = shadow_d;
    end
`endif
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    feeder_lane #(
      .WIDTH (WIDTH),
      .LANE  (i)
    ) u_lane (
      .mat_i    (mat_d),
      .t_i      (t_d),
      .active_i (busy_d),
      .data_o   (port_d[i*WIDTH +: WIDTH]),
      .valid_o  (valid_d[i])
    );
  end

  // Control and output registers; reset clears everything visible at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_q     <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      port_q  <= '0;
      valid_q <= '0;
`ifdef OPERAND_FEEDER_DOUBLE_BUFFER_EN
      shadow_full_q <= 1'b0;
`endif
    end else begin
      t_q     <= t_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      port_q  <= port_d;
      valid_q <= valid_d;
`ifdef OPERAND_FEEDER_DOUBLE_BUFFER_EN
      shadow_full_q <= shadow_full_d;
`endif
    end
  end

  // Matrix storage carries no reset; it is only read while busy.
  always_ff @(posedge clk) begin
    mat_q <= mat_d;
`ifdef OPERAND_FEEDER_DOUBLE_BUFFER_EN
    shadow_q <= shadow_d;
`endif
  end

  assign operand_port  = port_q;
  assign operand_valid = valid_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_operand_feeder.sv
// Directed bench for operand_feeder: streaming, stall, restart, start-while-busy and mid-stream reset.
module tb_operand_feeder;

  localparam int W = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            stall = 1'b0;
  logic [16*W-1:0] mat_in = '0;
  logic            ready;
  logic [4*W-1:0]  operand_port;
  logic [3:0]      operand_valid;
  logic            busy;
  logic            done;

  int n_cmp = 0;
  int n_err = 0;

  operand_feeder #(.WIDTH(W), .N(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .mat_in        (mat_in),
    .stall         (stall),
    .ready         (ready),
    .operand_port  (operand_port),
    .operand_valid (operand_valid),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Matrix whose element k holds base+k.
  function automatic logic [16*W-1:0] make_mat(input int base);
    logic [16*W-1:0] m;
    m = '0;
    for (int k = 0; k < 16; k++) m[k*W +: W] = W'(base + k);
    return m;
  endfunction

  // Expected skewed lanes at step t for make_mat(base): lane i shows element i*4+(t-i).
  function automatic logic [4*W-1:0] exp_port(input int base, input int t);
    logic [4*W-1:0] p;
    p = '0;
    for (int i = 0; i < 4; i++)
      if (t >= i && t < i + 4) p[i*W +: W] = W'(base + i*4 + (t - i));
    return p;
  endfunction

  function automatic logic [3:0] exp_valid(input int t);
    logic [3:0] v;
    v = 4'b0000;
    for (int i = 0; i < 4; i++)
      if (t >= i && t < i + 4) v[i] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b want=0", ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
    n_cmp++; if (operand_valid !== 4'b0000) begin n_err++; $display("FAIL reset_valid got=%b want=0000", operand_valid); end
    n_cmp++; if (operand_port !== '0) begin n_err++; $display("FAIL reset_port got=%h want=0", operand_port); end
    step();
    reset = 1'b1;
    step();
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got=%b want=1", ready); end
  endtask

  // Matrix 1..16, no stall: lane0 = 1..4 at t=0..3, lane3 = 13..16 at t=3..6, done in cycle 8.
  task automatic test_stream();
    start = 1'b1; mat_in = make_mat(1);
    step();
    start = 1'b0; mat_in = make_mat(900);
    for (int t = 0; t < 7; t++) begin
      n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL stream_ctl t=%0d busy=%b done=%b want busy=1 done=0", t, busy, done); end
      n_cmp++; if (operand_port !== exp_port(1, t)) begin n_err++; $display("FAIL stream_port t=%0d got=%h want=%h", t, operand_port, exp_port(1, t)); end
      n_cmp++; if (operand_valid !== exp_valid(t)) begin n_err++; $display("FAIL stream_valid t=%0d got=%b want=%b", t, operand_valid, exp_valid(t)); end
      if (t < 4) begin
        n_cmp++; if (operand_port[0 +: W] !== W'(t + 1)) begin n_err++; $display("FAIL stream_lane0 t=%0d got=%0d want=%0d", t, operand_port[0 +: W], t + 1); end
      end else begin
        n_cmp++; if (operand_valid[0] !== 1'b0) begin n_err++; $display("FAIL stream_lane0_off t=%0d got=%b want=0", t, operand_valid[0]); end
      end
      if (t >= 3) begin
        n_cmp++; if (operand_port[3*W +: W] !== W'(t + 10)) begin n_err++; $display("FAIL stream_lane3 t=%0d got=%0d want=%0d", t, operand_port[3*W +: W], t + 10); end
      end else begin
        n_cmp++; if (operand_valid[3] !== 1'b0) begin n_err++; $display("FAIL stream_lane3_off t=%0d got=%b want=0", t, operand_valid[3]); end
      end
      step();
    end
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL stream_done done=%b busy=%b want done=1 busy=0", done, busy); end
    n_cmp++; if (operand_port !== '0 || operand_valid !== 4'b0000) begin n_err++; $display("FAIL stream_idle_out port=%h valid=%b want zero", operand_port, operand_valid); end
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL stream_ready got=%b want=1", ready); end
    step();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL stream_done_pulse got=%b want=0", done); end
  endtask

  // Stall for 3 cycles at t=2: everything frozen, done lands in cycle 11 instead of 8.
  task automatic test_stall();
    int cyc;
    start = 1'b1; mat_in = make_mat(17);
    step();
    start = 1'b0;
    cyc = 1;
    for (int t = 0; t < 7; t++) begin
      n_cmp++; if (operand_port !== exp_port(17, t) || operand_valid !== exp_valid(t)) begin n_err++; $display("FAIL stall_stream t=%0d port=%h valid=%b want %h %b", t, operand_port, operand_valid, exp_port(17, t), exp_valid(t)); end
      if (t == 2) begin
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
          step(); cyc++;
          n_cmp++; if (operand_port !== exp_port(17, 2) || operand_valid !== exp_valid(2) || busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL stall_hold s=%0d port=%h valid=%b busy=%b done=%b", s, operand_port, operand_valid, busy, done); end
        end
        stall = 1'b0;
      end
      step(); cyc++;
    end
    n_cmp++; if (done !== 1'b1 || cyc != 11) begin n_err++; $display("FAIL stall_done done=%b cycle=%0d want done=1 cycle=11", done, cyc); end
    step();
  endtask

  // Stall while idle does not block acceptance.
  task automatic test_stall_idle();
    stall = 1'b1;
    step();
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL stall_idle busy=%b done=%b want 0 0", busy, done); end
    start = 1'b1; mat_in = make_mat(300);
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL stall_idle_ready got=%b want=1", ready); end
    step();
    start = 1'b0; stall = 1'b0;
    for (int t = 0; t < 7; t++) begin
      n_cmp++; if (operand_port !== exp_port(300, t) || busy !== 1'b1) begin n_err++; $display("FAIL stall_idle_stream t=%0d port=%h busy=%b want %h 1", t, operand_port, busy, exp_port(300, t)); end
      step();
    end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL stall_idle_done got=%b want=1", done); end
    step();
  endtask

  // New start in the done cycle: its t=0 follows directly.
  task automatic test_back_to_back();
    start = 1'b1; mat_in = make_mat(33);
    step();
    start = 1'b0;
    repeat (7) step();
    n_cmp++; if (done !== 1'b1 || ready !== 1'b1) begin n_err++; $display("FAIL b2b_done done=%b ready=%b want 1 1", done, ready); end
    start = 1'b1; mat_in = make_mat(49);
    step();
    start = 1'b0;
    for (int t = 0; t < 7; t++) begin
      n_cmp++; if (operand_port !== exp_port(49, t) || operand_valid !== exp_valid(t) || busy !== 1'b1) begin n_err++; $display("FAIL b2b_stream t=%0d port=%h valid=%b busy=%b", t, operand_port, operand_valid, busy); end
      step();
    end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done2 got=%b want=1", done); end
    step();
  endtask

`ifdef OPERAND_FEEDER_DOUBLE_BUFFER_EN
  // A then B queued in the shadow: B's t=0 follows A's t=6, two done pulses.
  task automatic test_double_buffer();
    int n_done;
    n_done = 0;
    start = 1'b1; mat_in = make_mat(1);
    step();
    mat_in = make_mat(101);
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL db_ready_empty got=%b want=1", ready); end
    step();
    start = 1'b0;
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL db_ready_full got=%b want=0", ready); end
    for (int c = 1; c < 15; c++) begin
      if (done === 1'b1) n_done++;
      if (c < 7) begin
        n_cmp++; if (operand_port !== exp_port(1, c) || busy !== 1'b1) begin n_err++; $display("FAIL db_a t=%0d port=%h busy=%b", c, operand_port, busy); end
      end else if (c < 14) begin
        n_cmp++; if (operand_port !== exp_port(101, c - 7) || busy !== 1'b1 || done !== (c == 7)) begin n_err++; $display("FAIL db_b t=%0d port=%h busy=%b done=%b", c - 7, operand_port, busy, done); end
      end else begin
        n_cmp++; if (busy !== 1'b0 || done !== 1'b1) begin n_err++; $display("FAIL db_end busy=%b done=%b want 0 1", busy, done); end
      end
      step();
    end
    n_cmp++; if (n_done != 2) begin n_err++; $display("FAIL db_done_count got=%0d want=2", n_done); end
  endtask
`else
  // Start held high while busy is ignored; exactly one done.
  task automatic test_start_ignored();
    int n_done;
    n_done = 0;
    start = 1'b1; mat_in = make_mat(65);
    step();
    mat_in = make_mat(200);
    for (int t = 0; t < 7; t++) begin
      if (t == 6) start = 1'b0;
      n_cmp++; if (operand_port !== exp_port(65, t) || ready !== 1'b0) begin n_err++; $display("FAIL ignore_stream t=%0d port=%h ready=%b", t, operand_port, ready); end
      step();
    end
    for (int c = 0; c < 8; c++) begin
      if (done === 1'b1) n_done++;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_restart c=%0d busy=%b want=0", c, busy); end
      step();
    end
    n_cmp++; if (n_done != 1) begin n_err++; $display("FAIL ignore_done_count got=%0d want=1", n_done); end
  endtask
`endif

  // Reset at t=4 zeroes outputs at once, no done; a fresh start streams normally.
  task automatic test_reset_mid();
    int n_done;
    n_done = 0;
    start = 1'b1; mat_in = make_mat(1);
    step();
    start = 1'b0;
    repeat (4) step();
    n_cmp++; if (operand_port !== exp_port(1, 4)) begin n_err++; $display("FAIL rmid_pre port=%h want=%h", operand_port, exp_port(1, 4)); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (operand_port !== '0 || operand_valid !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || ready !== 1'b0) begin n_err++; $display("FAIL rmid_async port=%h valid=%b busy=%b done=%b ready=%b", operand_port, operand_valid, busy, done, ready); end
    repeat (3) begin
      step();
      if (done === 1'b1) n_done++;
    end
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (done === 1'b1) n_done++;
    end
    n_cmp++; if (n_done != 0 || busy !== 1'b0) begin n_err++; $display("FAIL rmid_no_done dones=%0d busy=%b want 0 0", n_done, busy); end
    start = 1'b1; mat_in = make_mat(201);
    step();
    start = 1'b0;
    for (int t = 0; t < 7; t++) begin
      n_cmp++; if (operand_port !== exp_port(201, t) || operand_valid !== exp_valid(t)) begin n_err++; $display("FAIL rmid_restart t=%0d port=%h valid=%b", t, operand_port, operand_valid); end
      step();
    end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL rmid_restart_done got=%b want=1", done); end
    step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_stall_idle();
    test_back_to_back();
`ifdef OPERAND_FEEDER_DOUBLE_BUFFER_EN
    test_double_buffer();
`else
    test_start_ignored();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
